// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the video path.
// Holds the default 800x600@60 Hz (40 MHz pixel clock) timing, the counter
// width, and the timing bundle type that draw stages pass down their pipelines.
// Optional feature macro used by the top: VGA_TIMING_FRAME_CNT_EN.

package vga_timing_pkg;

   // Counter width; both axes must fit in this many bits.
   localparam int CNT_W = 11;

   // Horizontal defaults, in pixels.
   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 40;
   localparam int DEF_H_SYNC   = 128;
   localparam int DEF_H_BP     = 88;

   // Vertical defaults, in lines.
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 23;

   // Sync active level: 1 = active-high.
   localparam bit DEF_SYNC_POL = 1'b1;

   // Timing bundle as seen by every draw stage.
   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
   } vga_timing_t;

   // Length of one axis period from its four segments.
   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus registered blank and
// sync decode. The decode is computed from the counter's next value so that
// blank/sync always describe the same position as the count they sit beside.
// The wrap flag is high on the cycle the counter is at its last position and
// is being advanced, i.e. the cycle whose edge takes it back to 0.

module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE   = DEF_H_ACTIVE,
   parameter int FP       = DEF_H_FP,
   parameter int SYNC     = DEF_H_SYNC,
   parameter int BP       = DEF_H_BP,
   parameter bit SYNC_POL = DEF_SYNC_POL
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             blnk,
   output logic             sync,
   output logic             wrap
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam int EXT_W = CNT_W + 1;

   // Decode boundaries are one bit wider than the counter so that a sync
   // pulse ending exactly at TOTAL = 2**CNT_W still compares correctly.
   localparam logic [CNT_W:0]   ACTIVE_E     = EXT_W'(ACTIVE);
   localparam logic [CNT_W:0]   SYNC_START_E = EXT_W'(ACTIVE + FP);
   localparam logic [CNT_W:0]   SYNC_END_E   = EXT_W'(ACTIVE + FP + SYNC);
   localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(TOTAL - 1);

   if (TOTAL > (1 << CNT_W)) begin : g_total_too_big
      $error("vga_axis_counter: axis total %0d does not fit in %0d bits",
             TOTAL, CNT_W);
   end

   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W:0]   nxt_ext;
   logic             last;
   logic             in_sync_nxt;

   // Next position and the decode of that position.
   always_comb begin
      count_nxt   = (count == LAST_C) ? '0 : count + 1'b1;
      nxt_ext     = {1'b0, count_nxt};
      in_sync_nxt = (nxt_ext >= SYNC_START_E) && (nxt_ext < SYNC_END_E);
   end

   // Position, decode and terminal flag advance together, only when enabled.
   always_ff @(posedge pclk) begin
      if (!rst) begin
         count <= '0;
         blnk  <= 1'b0;
         sync  <= ~SYNC_POL;
         last  <= 1'b0;
      end else if (inc) begin
         count <= count_nxt;
         blnk  <= (nxt_ext >= ACTIVE_E);
         sync  <= in_sync_nxt ? SYNC_POL : ~SYNC_POL;
         last  <= (count_nxt == LAST_C);
      end
   end

   assign wrap = inc & last;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source for the draw pipeline (800x600@60 Hz by default).
// Two axis counters are chained: the vertical axis steps only when the
// horizontal axis wraps. All position, sync and blank outputs are registered
// with zero skew between them; line_tick/frame_tick are the registered
// last-pixel flags qualified by en, so they drop to 0 whenever en is low.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame
// counter (frame_cnt) for animation and blink timing.

module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = DEF_SYNC_POL
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] hcount_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             hblnk_out,
   output logic             vblnk_out,
   output logic             line_tick,
   output logic             frame_tick
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   vga_timing_t      timing;
   logic [CNT_W-1:0] h_count;
   logic [CNT_W-1:0] v_count;
   logic             h_sync;
   logic             v_sync;
   logic             h_blnk;
   logic             v_blnk;
   logic             h_wrap;
   logic             v_wrap;
   logic             v_inc;

   vga_axis_counter #(
      .ACTIVE   (H_ACTIVE),
      .FP       (H_FP),
      .SYNC     (H_SYNC),
      .BP       (H_BP),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .pclk  (pclk),
      .rst   (rst),
      .inc   (en),
      .count (h_count),
      .blnk  (h_blnk),
      .sync  (h_sync),
      .wrap  (h_wrap)
   );

   // Vertical axis is line based: it moves only on the horizontal wrap.
   assign v_inc = h_wrap & en;

   vga_axis_counter #(
      .ACTIVE   (V_ACTIVE),
      .FP       (V_FP),
      .SYNC     (V_SYNC),
      .BP       (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .pclk  (pclk),
      .rst   (rst),
      .inc   (v_inc),
      .count (v_count),
      .blnk  (v_blnk),
      .sync  (v_sync),
      .wrap  (v_wrap)
   );

   assign timing = '{
      hcount: h_count,
      vcount: v_count,
      hsync:  h_sync,
      vsync:  v_sync,
      hblnk:  h_blnk,
      vblnk:  v_blnk
   };

   assign hcount_out = timing.hcount;
   assign vcount_out = timing.vcount;
   assign hsync_out  = timing.hsync;
   assign vsync_out  = timing.vsync;
   assign hblnk_out  = timing.hblnk;
   assign vblnk_out  = timing.vblnk;

   // A wrap is "last pixel while advancing", which is exactly the strobe
   // definition; the frame wrap can only occur on a line wrap.
   assign line_tick  = h_wrap;
   assign frame_tick = v_wrap;

`ifdef VGA_TIMING_FRAME_CNT_EN
   // Frame counter steps on the edge that returns vcount to 0.
   always_ff @(posedge pclk) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (v_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (32 x 16) so whole frames
// are short. A pixel-position reference model checks every cycle; a table of
// hand-derived vectors and a few directed sequences cover the corner cases.

module tb_vga_timing_gen;

   localparam int HA = 16;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 4;
   localparam int VA = 10;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam bit POL = 1'b1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic        pclk = 1'b0;
   logic        rst  = 1'b0;
   logic        en   = 1'b0;
   logic [10:0] hcount_out;
   logic [10:0] vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        hblnk_out;
   logic        vblnk_out;
   logic        line_tick;
   logic        frame_tick;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (POL)
   ) dut (
      .pclk       (pclk),
      .rst        (rst),
      .en         (en),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .line_tick  (line_tick),
      .frame_tick (frame_tick)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt  (frame_cnt)
`endif
   );

   always #5 pclk = ~pclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: raster position and frame number.
   int m_h = 0;
   int m_v = 0;
   int m_fc = 0;
   bit m_valid = 1'b0;

   bit counting = 1'b0;
   int cnt_lt = 0;
   int cnt_ft = 0;
   int cnt_hs = 0;
   int cnt_vs = 0;

   typedef struct {
      bit r;
      bit e;
      int n;
      int h;
      int v;
      bit hs;
      bit vs;
      bit hb;
      bit vb;
      bit lt;
      bit ft;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [27:0] model_vec(input bit e);
      bit hs, vs, hb, vb, lt, ft;
      hb = (m_h >= HA);
      vb = (m_v >= VA);
      hs = (m_h >= HA + HF && m_h < HA + HF + HS) ? POL : !POL;
      vs = (m_v >= VA + VF && m_v < VA + VF + VS) ? POL : !POL;
      lt = e && (m_h == HT - 1);
      ft = lt && (m_v == VT - 1);
      return {11'(m_h), 11'(m_v), hs, vs, hb, vb, lt, ft};
   endfunction

   function automatic void model_step(input bit r, input bit e);
      if (!r) begin
         m_h = 0;
         m_v = 0;
         m_fc = 0;
         m_valid = 1'b1;
      end else if (m_valid && e) begin
         m_h++;
         if (m_h == HT) begin
            m_h = 0;
            m_v++;
            if (m_v == VT) begin
               m_v = 0;
               m_fc = (m_fc + 1) % 65536;
            end
         end
      end
   endfunction

   function automatic logic [27:0] dut_vec();
      return {hcount_out, vcount_out, hsync_out, vsync_out,
              hblnk_out, vblnk_out, line_tick, frame_tick};
   endfunction

   // Drive inputs, check the current pixel against the model, then clock.
   task automatic cycle(input bit r, input bit e);
      rst = r;
      en  = e;
      #1;
      if (m_valid) begin
         chk("model", 32'(dut_vec()), 32'(model_vec(e)));
`ifdef VGA_TIMING_FRAME_CNT_EN
         chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
`endif
      end
      if (counting) begin
         cnt_lt += int'(line_tick);
         cnt_ft += int'(frame_tick);
         cnt_hs += int'(hsync_out == POL);
         cnt_vs += int'(vsync_out == POL);
      end
      @(posedge pclk);
      #1;
      model_step(r, e);
   endtask

   initial begin
      //            r  e  n    h   v  hs vs hb vb lt ft
      tbl[0]  = '{1'b0, 1'b1,   3,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1,   1,  1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1,  30, 31,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0,  10, 31,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1,   1,  0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 288,  0, 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1,  32,  0, 11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 159, 31, 15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 1'b1,   1,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1,  24, 24,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1,   1,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 11; i++) begin
         for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].r, tbl[i].e);
         rst = tbl[i].r;
         en  = tbl[i].e;
         #1;
         chk($sformatf("row%0d", i), 32'(dut_vec()),
             32'({11'(tbl[i].h), 11'(tbl[i].v), tbl[i].hs, tbl[i].vs,
                  tbl[i].hb, tbl[i].vb, tbl[i].lt, tbl[i].ft}));
      end

      // One whole frame from reset: tally strobes and sync widths.
      cycle(1'b0, 1'b1);
      counting = 1'b1;
      repeat (HT * VT) cycle(1'b1, 1'b1);
      counting = 1'b0;
      chk("line_ticks_per_frame", 32'(cnt_lt), 32'(VT));
      chk("frame_ticks_per_frame", 32'(cnt_ft), 32'd1);
      chk("hsync_cycles_per_frame", 32'(cnt_hs), 32'(VT * HS));
      chk("vsync_cycles_per_frame", 32'(cnt_vs), 32'(VS * HT));
      chk("frame_return_h", 32'(hcount_out), 32'd0);
      chk("frame_return_v", 32'(vcount_out), 32'd0);

      // Reset in the middle of an hsync pulse.
      repeat (5 * HT + 20) cycle(1'b1, 1'b1);
      chk("mid_hsync_active", 32'(hsync_out), 32'(POL));
      cycle(1'b0, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_reset_h", 32'(hcount_out), 32'd0);
      chk("mid_reset_v", 32'(vcount_out), 32'd0);
      chk("mid_reset_hsync", 32'(hsync_out), 32'(!POL));
      cycle(1'b1, 1'b1);
      chk("resume_h", 32'(hcount_out), 32'd1);

`ifdef VGA_TIMING_FRAME_CNT_EN
      cycle(1'b0, 1'b1);
      repeat (3 * HT * VT) cycle(1'b1, 1'b1);
      chk("frame_cnt_three", 32'(frame_cnt), 32'd3);
      chk("frame_cnt_pos", 32'({hcount_out, vcount_out}), 32'd0);
`endif

      // Randomized enable with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom_range(0, 399) != 0), ($urandom_range(0, 9) < 8));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Source of the raster timing stream consumed by every draw stage: text overlays, sprite and rectangle drawers. Produces hcount, vcount, hsync, vsync, hblnk and vblnk for 800x600@60 Hz (40 MHz pclk) by default.
Adds line and frame strobes for game logic. All outputs are registered and mutually aligned, so downstream stages may pipeline them with uniform one-cycle delays.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync pulse width (pixels)
H_BP, 88, horizontal back porch (pixels); H_TOTAL = sum of the four H params = 1056
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum of the four V params = 628
SYNC_POL, 1, sync active level (1 = active-high)

Ports:
pclk  in  1  pixel clock
rst  in  1  reset; synchronous, active-low (asserted when 0)
en  in  1  advance enable; counters hold when 0
hcount_out  out  11  horizontal position, 0..H_TOTAL-1
vcount_out  out  11  vertical position, 0..V_TOTAL-1
hsync_out  out  1  horizontal sync
vsync_out  out  1  vertical sync
hblnk_out  out  1  high when hcount_out >= H_ACTIVE
vblnk_out  out  1  high when vcount_out >= V_ACTIVE
line_tick  out  1  one-cycle strobe on the last pixel of every line
frame_tick  out  1  one-cycle strobe on the last pixel of the frame

Behaviour:
- Reset (rst==0 at a pclk edge):
  - hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0.
  - hsync_out and vsync_out at their inactive level (!SYNC_POL).
  - line_tick=0, frame_tick=0. Reset has priority over en.
- Counting when en==1:
  - hcount increments each cycle and wraps from H_TOTAL-1 to 0.
  - vcount increments only on that wrap, and wraps from V_TOTAL-1 to 0 when hcount also wraps.
- When en==0: every output holds its value, except line_tick and frame_tick, which are forced to 0.
- Decode is registered from next-state counter values, so every output describes the same pixel as hcount_out/vcount_out in the same cycle. There is zero skew between outputs.
- hsync_out active for H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (default 840..967).
- vsync_out active for V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (default 601..604). vsync is line-based: it changes together with vcount at hcount wrap.
- line_tick=1 exactly when hcount_out==H_TOTAL-1 and en==1.
- frame_tick=1 exactly when hcount_out==H_TOTAL-1, vcount_out==V_TOTAL-1 and en==1. frame_tick implies line_tick.
- Latency: the first cycle after reset release with en==1 shows hcount_out=1. Pixel (0,0) is the reset state.
- Reset mid-frame: the next cycle returns to (0,0) with no partial sync pulses extended.
- Widths: 11-bit counters. Parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 2048; otherwise elaboration fails.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- With the macro:
  - adds output frame_cnt [15:0], reset 0.
  - frame_cnt increments (mod 65536) in the same cycle that vcount_out returns to 0.
  - holds while en==0.
  - intended for animation and blink timing in text overlays.
- Without the macro: the port and register are absent.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (H_ACTIVE..V_BP for 800x600);
  - the 11-bit count width constant;
  - a typedef for the {hcount, vcount, hsync, vsync, hblnk, vblnk} timing bundle, reused by draw stages.
- One sub-module, vga_axis_counter, is instantiated twice:
  - it holds the wrap counter with an increment enable;
  - it registers the blank and sync decode from ACTIVE/FP/SYNC/TOTAL parameters;
  - it produces a wrap flag.
- The vertical instance's increment enable is the horizontal instance's wrap AND en.

Test Plan:
- Hold rst=0 for 3 cycles, release with en=1 → reset cycle shows (0,0), syncs inactive, blanks 0; next cycle hcount_out=1.
- Run one line → hblnk_out rises at hcount 800; hsync_out high for hcount 840..967 (128 cycles); line_tick only at hcount 1055; vcount 0→1 on the next cycle.
- Run full frame (663168 cycles) → vblnk_out from vcount 600; vsync_out high for lines 601..604 (4×1056 cycles); exactly one frame_tick at (1055,627); counters return to (0,0).
- Toggle en=0 for 10 cycles at hcount 1055 → all outputs frozen, line_tick=0 while en=0; line_tick reappears on the first en=1 cycle, then the wrap.
- Assert rst at (500,300) → next cycle (0,0) with sync/blank reset values; counting resumes normally.
- With VGA_TIMING_FRAME_CNT_EN, run 3 frames → frame_cnt reads 3 at (0,0) of the fourth frame. Force frame_cnt to 65535 → it wraps to 0.
